spike_raster_buffer: RTL and testbench

- Downstream of the Izhikevich simulation core. Consumes the per-neuron spike result stream the core emits while it sweeps neurons 0..size-1 each timestep.
- Packs spike bits into 16-bit raster words and tags each word with timestep and word index.
- Buffers tagged words in a first-word-fall-through FIFO that the host drains through a valid/ready handshake.

---
 rtl/spike_raster_buffer_if.sv | 29 ++
 rtl/spike_raster_buffer.sv | 180 ++++++++++++++++++
 tb/tb_spike_raster_buffer.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_raster_buffer_if.sv
// Spike-result and raster-word handshake bundle between the core, the raster buffer and the host.
// Latency: none (wires only).
// Backpressure: only the out* side has flow control (outReady); spike results cannot be stalled.
interface spike_raster_buffer_if #(
  parameter int IDX_W = 10,
  parameter int TS_W  = 10
);
  logic              spkValid;
  logic [IDX_W-1:0]  spkIdx;
  logic              spkFire;
  logic [TS_W-1:0]   spkTimestep;
  logic              outValid;
  logic              outReady;
  logic [15:0]       outData;
  logic [TS_W-1:0]   outTimestep;
  logic [IDX_W-5:0]  outWordIdx;

  // Producer of spikes / consumer of raster words (core + host side)
  modport master (
    output spkValid, spkIdx, spkFire, spkTimestep, outReady,
    input  outValid, outData, outTimestep, outWordIdx
  );

  // The raster buffer itself
  modport slave (
    input  spkValid, spkIdx, spkFire, spkTimestep, outReady,
    output outValid, outData, outTimestep, outWordIdx
  );
endinterface

// File: rtl/spike_raster_buffer.sv
// Packs per-neuron spike results into tagged 16-bit raster words and queues them in an FWFT FIFO.
// Latency: closing spike sampled at edge N -> word at FIFO head (outValid=1) after edge N+1 when empty.
// Backpressure: none toward the core; host drains via outValid/outReady, words arriving at a full FIFO are dropped (sticky overflow).
// Optional build macro SPIKE_SKIP_EMPTY_EN: all-zero closed words are not queued.
module spike_raster_buffer #(
  parameter int IDX_W = 10,
  parameter int TS_W  = 10,
  parameter int DEPTH = 64,
  parameter int CNT_W = 7
) (
  input  logic               clk,
  input  logic               aclr,
  input  logic               clear,
  input  logic [IDX_W-1:0]   size,
  spike_raster_buffer_if.slave bus,
  output logic [CNT_W-1:0]   count,
  output logic               overflow,
  output logic               seqErr
);

  localparam int WI_W  = IDX_W - 4;
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [15:0]     bits;
    logic [TS_W-1:0] ts;
    logic [WI_W-1:0] widx;
  } word_t;

  // Packer / sequence state
  logic [15:0]      acc_q, acc_d;
  logic [IDX_W-1:0] exp_idx_q, exp_idx_d;
  logic             seq_err_q, seq_err_d;
  logic             pend_vld_q, pend_vld_d;
  word_t            pend_q, pend_d;

  // FIFO state
  word_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_vld_q, out_vld_d;
  word_t            head_q, head_d;
  logic             overflow_q, overflow_d;

  // Packer helpers
  logic [3:0]       bit_pos;
  logic [15:0]      acc_bits;
  logic             size_end;
  logic             close_word;

  // FIFO helpers
  logic             pop;
  logic             full;
  logic             push_ok;
  logic             drop;
  logic             mem_we;

  // Packer: merge the current spike into the accumulator, close words, track expected index
  always_comb begin
    bit_pos           = bus.spkIdx[3:0];
    acc_bits          = acc_q;
    acc_bits[bit_pos] = bus.spkFire;
    size_end          = (size != '0) && (bus.spkIdx == (size - IDX_W'(1)));
    close_word        = bus.spkValid && ((bit_pos == 4'hF) || size_end);

    acc_d      = acc_q;
    exp_idx_d  = exp_idx_q;
    seq_err_d  = seq_err_q;
    pend_vld_d = 1'b0;
    pend_d     = pend_q;

    if (bus.spkValid) begin
      if (bus.spkIdx != exp_idx_q) begin
        seq_err_d = 1'b1;
      end
      // Resync to the index actually seen so a single glitch reports once
      exp_idx_d = size_end ? '0 : (bus.spkIdx + IDX_W'(1));
      acc_d     = close_word ? '0 : acc_bits;
    end

    if (close_word) begin
      pend_d = '{bits: acc_bits, ts: bus.spkTimestep, widx: bus.spkIdx[IDX_W-1:4]};
`ifdef SPIKE_SKIP_EMPTY_EN
      pend_vld_d = |acc_bits;
`else
      pend_vld_d = 1'b1;
`endif
    end

    if (clear) begin
      acc_d      = '0;
      exp_idx_d  = '0;
      seq_err_d  = 1'b0;
      pend_vld_d = 1'b0;
      pend_d     = '0;
    end
  end

  // FIFO control: push/pop arbitration, occupancy, and next head value for the registered outputs
  always_comb begin
    pop     = out_vld_q && bus.outReady;
    full    = (count_q == CNT_W'(DEPTH));
    push_ok = pend_vld_q && (!full || pop);
    drop    = pend_vld_q && full && !pop;

    wr_ptr_d   = wr_ptr_q + (push_ok ? PTR_W'(1) : PTR_W'(0));
    rd_ptr_d   = rd_ptr_q + (pop ? PTR_W'(1) : PTR_W'(0));
    count_d    = count_q + (push_ok ? CNT_W'(1) : CNT_W'(0)) - (pop ? CNT_W'(1) : CNT_W'(0));
    overflow_d = overflow_q | drop;
    out_vld_d  = (count_d != '0);
    mem_we     = push_ok;

    // Head holds its last value while empty; a word written this edge into the
    // new head slot is forwarded since the memory write lands on the same edge.
    head_d = head_q;
    if (count_d != '0) begin
      if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
        head_d = pend_q;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end

    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      out_vld_d  = 1'b0;
      head_d     = '0;
      mem_we     = 1'b0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      acc_q      <= '0;
      exp_idx_q  <= '0;
      seq_err_q  <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_vld_q  <= 1'b0;
      head_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      exp_idx_q  <= exp_idx_d;
      seq_err_q  <= seq_err_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_vld_q  <= out_vld_d;
      head_q     <= head_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= pend_q;
    end
  end

  assign bus.outValid    = out_vld_q;
  assign bus.outData     = head_q.bits;
  assign bus.outTimestep = head_q.ts;
  assign bus.outWordIdx  = head_q.widx;
  assign count           = count_q;
  assign overflow        = overflow_q;
  assign seqErr          = seq_err_q;

endmodule

// File: tb/tb_spike_raster_buffer.sv
// Self-checking bench for spike_raster_buffer: directed scenarios plus randomized sweeps,
// checked every cycle against a queue-based reference model of the packer and FIFO.
module tb_spike_raster_buffer;
  localparam int IDX_W = 10;
  localparam int TS_W  = 10;
  localparam int DEPTH = 64;
  localparam int CNT_W = 7;

  typedef struct packed {
    logic [15:0] d;
    logic [9:0]  ts;
    logic [5:0]  w;
  } wd_t;

  logic             clk = 1'b0;
  logic             aclr = 1'b1;
  logic             clear = 1'b0;
  logic [IDX_W-1:0] size = '0;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             seq_err;

  spike_raster_buffer_if #(.IDX_W(IDX_W), .TS_W(TS_W)) bus ();

  spike_raster_buffer #(.IDX_W(IDX_W), .TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .aclr     (aclr),
    .clear    (clear),
    .size     (size),
    .bus      (bus),
    .count    (count),
    .overflow (overflow),
    .seqErr   (seq_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int last_pop_ts = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  wd_t m_q[$];
  wd_t m_last = '0;
  wd_t m_pend = '0;
  bit  m_pend_v = 1'b0;
  bit  m_ovf = 1'b0;
  bit  m_seq = 1'b0;
  int  m_exp = 0;
  bit  fired [1024];

  task automatic m_reset();
    m_q.delete();
    m_last   = '0;
    m_pend   = '0;
    m_pend_v = 1'b0;
    m_ovf    = 1'b0;
    m_seq    = 1'b0;
    m_exp    = 0;
    foreach (fired[i]) fired[i] = 1'b0;
  endtask

  task automatic model_step();
    bit  do_pop;
    bit  is_full;
    int  idx;
    int  base;
    wd_t w;
    if (aclr || clear) begin
      m_reset();
      return;
    end
    do_pop  = (m_q.size() > 0) && bus.outReady;
    is_full = (m_q.size() == DEPTH);
    if (do_pop) void'(m_q.pop_front());
    if (m_pend_v) begin
      if (is_full && !do_pop) m_ovf = 1'b1;
      else m_q.push_back(m_pend);
    end
    m_pend_v = 1'b0;
    if (bus.spkValid) begin
      idx = int'(bus.spkIdx);
      if (idx != m_exp) m_seq = 1'b1;
      m_exp = (size != 0 && idx == int'(size) - 1) ? 0 : (idx + 1) % 1024;
      fired[idx] = bus.spkFire;
      if ((idx % 16 == 15) || (size != 0 && idx == int'(size) - 1)) begin
        base = idx - (idx % 16);
        w = '0;
        for (int k = 0; k < 16; k++) begin
          w.d[k] = fired[base + k];
          fired[base + k] = 1'b0;
        end
        w.ts = bus.spkTimestep;
        w.w  = 6'(idx / 16);
`ifdef SPIKE_SKIP_EMPTY_EN
        if (w.d != 16'h0) begin
          m_pend = w;
          m_pend_v = 1'b1;
        end
`else
        m_pend = w;
        m_pend_v = 1'b1;
`endif
      end
    end
    if (m_q.size() > 0) m_last = m_q[0];
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge aclr);
      model_step();
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("mon_valid",    32'(bus.outValid),    32'(m_q.size() > 0));
      chk("mon_count",    32'(count),           32'(m_q.size()));
      chk("mon_overflow", 32'(overflow),        32'(m_ovf));
      chk("mon_seqerr",   32'(seq_err),         32'(m_seq));
      chk("mon_data",     32'(bus.outData),     32'(m_last.d));
      chk("mon_ts",       32'(bus.outTimestep), 32'(m_last.ts));
      chk("mon_widx",     32'(bus.outWordIdx),  32'(m_last.w));
      if (bus.outValid && bus.outReady) last_pop_ts = int'(bus.outTimestep);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic spike(input int idx, input bit fire, input int ts);
    bus.spkValid    = 1'b1;
    bus.spkIdx      = IDX_W'(idx);
    bus.spkFire     = fire;
    bus.spkTimestep = TS_W'(ts);
    cyc();
    bus.spkValid    = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic drain();
    int b;
    b = 0;
    bus.outReady = 1'b1;
    while ((m_q.size() != 0 || m_pend_v) && b < 500) begin
      cyc();
      b++;
    end
    chk("drain_timeout", 32'(m_q.size()), 32'd0);
    bus.outReady = 1'b0;
    cyc();
  endtask

  task automatic fill_timesteps(input int n, input int first_ts);
    for (int t = 0; t < n; t++)
      for (int i = 0; i < 16; i++) spike(i, 1'($urandom), first_ts + t);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int sizes [5] = '{16, 20, 33, 48, 7};
    bus.spkValid    = 1'b0;
    bus.spkIdx      = '0;
    bus.spkFire     = 1'b0;
    bus.spkTimestep = '0;
    bus.outReady    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.outValid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_data",  32'(bus.outData), 32'd0);
    aclr = 1'b0;
    cyc();

    // T1: size 20, fires at 1, 15, 17
    do_clear();
    size = 10'd20;
    bus.outReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      spike(i, (i == 1 || i == 15 || i == 17), 3);
      if (i == 15) chk("t1_not_yet_valid", 32'(bus.outValid), 32'd0);
      if (i == 16) begin
        chk("t1_first_valid", 32'(bus.outValid), 32'd1);
        chk("t1_first_data",  32'(bus.outData), 32'h8002);
        chk("t1_first_ts",    32'(bus.outTimestep), 32'd3);
        chk("t1_first_widx",  32'(bus.outWordIdx), 32'd0);
      end
    end
    cyc();
    chk("t1_second_data", 32'(bus.outData), 32'h0002);
    chk("t1_second_widx", 32'(bus.outWordIdx), 32'd1);
    idle(3);
    chk("t1_seqerr", 32'(seq_err), 32'd0);
    drain();

    // T4: out-of-order index
    do_clear();
    size = 10'd32;
    bus.outReady = 1'b1;
    for (int i = 0; i < 5; i++) spike(i, 1'($urandom), 4);
    chk("t4_seqerr_before", 32'(seq_err), 32'd0);
    spike(7, 1'b1, 4);
    chk("t4_seqerr_set", 32'(seq_err), 32'd1);
    for (int i = 8; i < 32; i++) spike(i, 1'($urandom), 4);
    drain();

    // T2: overflow on the 65th word
    do_clear();
    size = 10'd16;
    fill_timesteps(65, 0);
    idle(3);
    chk("t2_count_full", 32'(count), 32'd64);
    chk("t2_overflow",   32'(overflow), 32'd1);
    drain();
    chk("t2_last_ts", 32'(last_pop_ts), 32'd63);

    // T3: push and pop on the same edge while full
    do_clear();
    size = 10'd16;
    fill_timesteps(64, 0);
    idle(2);
    chk("t3_count_full", 32'(count), 32'd64);
    for (int i = 0; i < 15; i++) spike(i, 1'($urandom), 64);
    spike(15, 1'b1, 64);
    bus.outReady = 1'b1;
    cyc();
    bus.outReady = 1'b0;
    cyc();
    chk("t3_count_kept", 32'(count), 32'd64);
    chk("t3_no_overflow", 32'(overflow), 32'd0);
    drain();
    chk("t3_tail_ts", 32'(last_pop_ts), 32'd64);

    // T5: asynchronous reset mid-word
    do_clear();
    size = 10'd0;
    spike(900, 1'b0, 5);
    for (int i = 0; i < 56; i++) spike(i, (i % 3 == 0), 5);
    idle(2);
    chk("t5_count_pre", 32'(count), 32'd3);
    #2;
    aclr = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(bus.outValid), 32'd0);
    chk("t5_rst_count", 32'(count), 32'd0);
    chk("t5_rst_data",  32'(bus.outData), 32'd0);
    chk("t5_rst_ts",    32'(bus.outTimestep), 32'd0);
    chk("t5_rst_widx",  32'(bus.outWordIdx), 32'd0);
    chk("t5_rst_seq",   32'(seq_err), 32'd0);
    chk("t5_rst_ovf",   32'(overflow), 32'd0);
    cyc();
    aclr = 1'b0;
    for (int i = 0; i < 16; i++) spike(i, 1'($urandom), 7);
    idle(3);
    chk("t5_one_word", 32'(count), 32'd1);
    drain();

    // T6: single fire at idx 40 of 48
    do_clear();
    size = 10'd48;
    for (int i = 0; i < 48; i++) spike(i, (i == 40), 9);
    idle(3);
`ifdef SPIKE_SKIP_EMPTY_EN
    chk("t6_count", 32'(count), 32'd1);
    chk("t6_data",  32'(bus.outData), 32'h0100);
    chk("t6_widx",  32'(bus.outWordIdx), 32'd2);
`else
    chk("t6_count", 32'(count), 32'd3);
    chk("t6_data",  32'(bus.outData), 32'h0000);
    chk("t6_widx",  32'(bus.outWordIdx), 32'd0);
`endif
    drain();

    // Randomized sweeps with idle gaps and random host readiness
    do_clear();
    for (int s = 0; s < 40; s++) begin
      int sz;
      sz = sizes[$urandom_range(0, 4)];
      size = IDX_W'(sz);
      for (int i = 0; i < sz; i++) begin
        while ($urandom_range(0, 3) == 0) begin
          bus.outReady = 1'($urandom);
          bus.spkIdx   = IDX_W'($urandom);
          bus.spkFire  = 1'($urandom);
          cyc();
        end
        bus.outReady = 1'($urandom);
        spike(i, ($urandom_range(0, 2) == 0), s);
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
